// File: rtl/ipv4_rx.sv
// ipv4_rx: IPv4 receive parser on the 16-bit datapath.
// Validates the IPv4 header against the local address and the TCP protocol
// number, strips header, options and Ethernet padding, and forwards only the
// TCP payload. Rejected packets give one drop_o pulse; aborted payloads give
// one cancel_o pulse.
// Optional build macro: IPV4_RX_CSUM_EN enables header checksum checking.
//
// state   | meaning
// IDLE    | waiting for a start beat, other words ignored
// HEAD    | capturing header words, word index in wcnt_q
// DATA    | forwarding payload, rem_q bytes still owed
// DISCARD | packet rejected, words ignored until next start
module ipv4_rx #(
   parameter int          DATA_W    = 16,
   parameter int          LEN_W     = 2,
   parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001,
   parameter logic [7:0]  PROTO_TCP = 8'd6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              valid_o,
   output logic              start_o,
   output logic [LEN_W-1:0]  len_o,
   output logic [DATA_W-1:0] data_o,
   output logic [31:0]       src_ip_o,
   output logic              drop_o,
   output logic              cancel_o
);

   typedef enum logic [1:0] {IDLE, HEAD, DATA, DISCARD} state_t;

   state_t            state_q, state_d;
   logic [4:0]        wcnt_q, wcnt_d;
   logic [15:0]       rem_q, rem_d;
   logic              first_q, first_d;

   logic [3:0]        ihl_q;
   logic [15:0]       tot_len_q;
   logic              frag_bad_q;
   logic [7:0]        proto_q;
   logic [31:0]       src_q;
   logic [15:0]       dst_hi_q, dst_lo_q;

   logic              valid_d, start_d, drop_d, cancel_d;
   logic [LEN_W-1:0]  len_d;
   logic [DATA_W-1:0] data_d;
   logic [31:0]       src_ip_d;

   logic              w0_ok, hdr_last, csum_ok, accept, short_ok;
   logic [15:0]       hdr_bytes, pay_len, in_len16, take16;
   logic [31:0]       dst_now;

   assign w0_ok     = (data_i[15:12] == 4'd4) && (data_i[11:8] >= 4'd5);
   assign hdr_bytes = {10'd0, ihl_q, 2'b00};
   assign hdr_last  = (wcnt_q == ({ihl_q, 1'b0} - 5'd1));
   // For IHL=5 the last destination word is on the bus during the decision
   assign dst_now   = {dst_hi_q, (wcnt_q == 5'd9) ? data_i : dst_lo_q};
   assign pay_len   = tot_len_q - hdr_bytes;
   assign in_len16  = {{(16-LEN_W){1'b0}}, len_i};
   assign take16    = (in_len16 < rem_q) ? in_len16 : rem_q;
   // A short final header word is legitimate only when the packet has no payload
   assign short_ok  = (len_i >= LEN_W'(2)) || (hdr_last && (tot_len_q == hdr_bytes));
   assign accept    = (tot_len_q >= hdr_bytes) && (proto_q == PROTO_TCP) &&
                      (dst_now == LOCAL_IP) && !frag_bad_q && csum_ok;

`ifdef IPV4_RX_CSUM_EN
   logic [15:0] csum_q, csum_nxt;
   logic [16:0] csum_raw;

   assign csum_raw = {1'b0, csum_q} + {1'b0, data_i};
   assign csum_nxt = csum_raw[15:0] + {15'd0, csum_raw[16]};
   assign csum_ok  = (csum_nxt == 16'hFFFF);

   // One's-complement running sum over header words, end-around carry per add
   always_ff @(posedge clk) begin
      if (reset)
         csum_q <= 16'd0;
      else if (valid_i && start_i)
         csum_q <= data_i;
      else if (valid_i && state_q == HEAD)
         csum_q <= csum_nxt;
   end
`else
   assign csum_ok = 1'b1;
`endif

   // Header field capture by word index
   always_ff @(posedge clk) begin
      if (reset) begin
         ihl_q      <= 4'd0;
         tot_len_q  <= 16'd0;
         frag_bad_q <= 1'b0;
         proto_q    <= 8'd0;
         src_q      <= 32'd0;
         dst_hi_q   <= 16'd0;
         dst_lo_q   <= 16'd0;
      end else if (valid_i && start_i) begin
         ihl_q <= data_i[11:8];
      end else if (valid_i && state_q == HEAD) begin
         case (wcnt_q)
            5'd1: tot_len_q      <= data_i;
            5'd3: frag_bad_q     <= data_i[13] | (|data_i[12:0]);
            5'd4: proto_q        <= data_i[7:0];
            5'd6: src_q[31:16]   <= data_i;
            5'd7: src_q[15:0]    <= data_i;
            5'd8: dst_hi_q       <= data_i;
            5'd9: dst_lo_q       <= data_i;
            default: ;
         endcase
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      rem_d    = rem_q;
      first_d  = first_q;
      valid_d  = 1'b0;
      start_d  = 1'b0;
      drop_d   = 1'b0;
      cancel_d = 1'b0;
      len_d    = len_o;
      data_d   = data_o;
      src_ip_d = src_ip_o;
      if (valid_i) begin
         if (start_i) begin
            cancel_d = (state_q == DATA);
            drop_d   = (state_q == HEAD);
            wcnt_d   = 5'd1;
            if (!w0_ok) begin
               state_d = DISCARD;
               drop_d  = 1'b1;
            end else if (len_i < LEN_W'(2)) begin
               state_d = IDLE;
               drop_d  = 1'b1;
            end else begin
               state_d = HEAD;
            end
         end else begin
            case (state_q)
               HEAD: begin
                  wcnt_d = wcnt_q + 5'd1;
                  if (!short_ok) begin
                     state_d = IDLE;
                     drop_d  = 1'b1;
                  end else if (hdr_last) begin
                     if (accept) begin
                        src_ip_d = src_q;
                        rem_d    = pay_len;
                        first_d  = 1'b1;
                        state_d  = (pay_len == 16'd0) ? IDLE : DATA;
                     end else begin
                        state_d = DISCARD;
                        drop_d  = 1'b1;
                     end
                  end
               end
               DATA: begin
                  valid_d = 1'b1;
                  start_d = first_q;
                  first_d = 1'b0;
                  len_d   = take16[LEN_W-1:0];
                  data_d  = (take16 == 16'd1) ? {data_i[15:8], 8'h00} : data_i;
                  rem_d   = rem_q - take16;
                  if ((len_i < LEN_W'(2)) && (rem_q > in_len16)) begin
                     cancel_d = 1'b1;
                     state_d  = IDLE;
                  end else if (rem_q == take16) begin
                     state_d = IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wcnt_q   <= 5'd0;
         rem_q    <= 16'd0;
         first_q  <= 1'b0;
         valid_o  <= 1'b0;
         start_o  <= 1'b0;
         drop_o   <= 1'b0;
         cancel_o <= 1'b0;
         len_o    <= '0;
         data_o   <= '0;
         src_ip_o <= 32'd0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         rem_q    <= rem_d;
         first_q  <= first_d;
         valid_o  <= valid_d;
         start_o  <= start_d;
         drop_o   <= drop_d;
         cancel_o <= cancel_d;
         len_o    <= len_d;
         data_o   <= data_d;
         src_ip_o <= src_ip_d;
      end
   end

endmodule

// File: tb/tb_ipv4_rx.sv
// Testbench for ipv4_rx: table of per-beat stimulus with expected outputs one
// cycle later, plus hand-written reset and source-address sequences.
module tb_ipv4_rx;

   logic        clk = 1'b0;
   logic        reset, valid_i, start_i;
   logic [15:0] data_i;
   logic [1:0]  len_i;
   logic        valid_o, start_o, drop_o, cancel_o;
   logic [1:0]  len_o;
   logic [15:0] data_o;
   logic [31:0] src_ip_o;

   always #5 clk = ~clk;

   ipv4_rx dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .start_i(start_i),
      .data_i(data_i), .len_i(len_i), .valid_o(valid_o), .start_o(start_o),
      .len_o(len_o), .data_o(data_o), .src_ip_o(src_ip_o), .drop_o(drop_o),
      .cancel_o(cancel_o)
   );

   typedef struct {
      logic        v;
      logic        s;
      logic [15:0] d;
      logic [1:0]  l;
      logic        ev;
      logic        es;
      logic [1:0]  el;
      logic [15:0] ed;
      logic        edrop;
      logic        ecan;
   } vec_t;

   localparam logic [31:0] LIP = 32'hC0A8_0001;
   localparam logic [31:0] SRC = 32'h0A00_0002;
`ifdef IPV4_RX_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   vec_t        vq[$];
   logic [15:0] hw [0:29];
   int          checks = 0;
   int          errors = 0;

   task automatic push(input logic v, input logic s, input logic [15:0] d, input logic [1:0] l,
                       input logic ev, input logic es, input logic [1:0] el, input logic [15:0] ed,
                       input logic edrop, input logic ecan);
      vec_t r;
      r.v = v; r.s = s; r.d = d; r.l = l;
      r.ev = ev; r.es = es; r.el = el; r.ed = ed; r.edrop = edrop; r.ecan = ecan;
      vq.push_back(r);
   endtask

   task automatic pay(input logic [15:0] d, input logic [1:0] l, input logic es,
                      input logic [1:0] el, input logic [15:0] ed, input logic ecan);
      push(1'b1, 1'b0, d, l, 1'b1, es, el, ed, 1'b0, ecan);
   endtask

   task automatic ign(input logic [15:0] d);
      push(1'b1, 1'b0, d, 2'd2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic pay4();
      pay(16'h0102, 2'd2, 1'b1, 2'd2, 16'h0102, 1'b0);
      pay(16'h0304, 2'd2, 1'b0, 2'd2, 16'h0304, 1'b0);
      pay(16'h0506, 2'd2, 1'b0, 2'd2, 16'h0506, 1'b0);
      pay(16'h0708, 2'd2, 1'b0, 2'd2, 16'h0708, 1'b0);
   endtask

   task automatic mk_hdr(input logic [3:0] ihl, input logic [15:0] tl, input logic [7:0] proto,
                         input logic [31:0] dst, input logic [31:0] src,
                         input logic [15:0] frag, input logic [15:0] cx);
      logic [31:0] acc;
      for (int i = 0; i < 30; i++) hw[i] = 16'hA000 + 16'(i);
      hw[0] = {4'h4, ihl, 8'h00};
      hw[1] = tl;
      hw[2] = 16'h1C46;
      hw[3] = frag;
      hw[4] = {8'h40, proto};
      hw[5] = 16'h0000;
      hw[6] = src[31:16];
      hw[7] = src[15:0];
      hw[8] = dst[31:16];
      hw[9] = dst[15:0];
      acc = 32'd0;
      for (int i = 0; i < 2 * int'(ihl); i++) acc = acc + {16'd0, hw[i]};
      acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
      acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
      hw[5] = ~acc[15:0] ^ cx;
   endtask

   task automatic hdr(input logic [3:0] ihl, input logic [15:0] tl, input logic [7:0] proto,
                      input logic [31:0] dst, input logic [15:0] frag, input logic [15:0] cx,
                      input int n, input logic w0_drop, input logic w0_can,
                      input logic end_drop, input logic [1:0] lastlen, input int gap_at);
      int last;
      mk_hdr(ihl, tl, proto, dst, SRC, frag, cx);
      last = 2 * int'(ihl) - 1;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at)
            push(1'b0, 1'b0, 16'hDEAD, 2'd2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
         push(1'b1, i == 0, hw[i], (i == last) ? lastlen : 2'd2, 1'b0, 1'b0, 2'd0, 16'h0,
              ((i == 0) && w0_drop) || ((i == last) && end_drop), (i == 0) && w0_can);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic beat(input logic s, input logic [15:0] d, input logic [1:0] l);
      valid_i = 1'b1; start_i = s; data_i = d; len_i = l;
      @(posedge clk); #1;
   endtask

   initial begin
      logic ok;
      reset = 1'b1; valid_i = 1'b0; start_i = 1'b0; data_i = 16'h0; len_i = 2'd0;

      // basic: IHL=5, total_len=28, payload 01..08, then padding
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      pay4();
      ign(16'h0000); ign(16'h0000);
      // total_len=25: last beat carries one byte, padding ignored
      hdr(4'd5, 16'd25, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      pay(16'h0102, 2'd2, 1'b1, 2'd2, 16'h0102, 1'b0);
      pay(16'h0304, 2'd2, 1'b0, 2'd2, 16'h0304, 1'b0);
      pay(16'h0566, 2'd2, 1'b0, 2'd1, 16'h0500, 1'b0);
      ign(16'h0000); ign(16'h0000); ign(16'h0000);
      push(1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
      // IHL=6 with options, 8 payload bytes
      hdr(4'd6, 16'd32, 8'd6, LIP, 16'h0, 16'h0, 12, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      pay4();
      // UDP rejected at header end, then a good packet with gaps
      hdr(4'd5, 16'd28, 8'd17, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b1, 2'd2, -1);
      ign(16'h0102); ign(16'h0304); ign(16'h0506); ign(16'h0708);
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, 3);
      pay(16'h0102, 2'd2, 1'b1, 2'd2, 16'h0102, 1'b0);
      push(1'b0, 1'b0, 16'hBEEF, 2'd2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
      pay(16'h0304, 2'd2, 1'b0, 2'd2, 16'h0304, 1'b0);
      pay(16'h0506, 2'd2, 1'b0, 2'd2, 16'h0506, 1'b0);
      pay(16'h0708, 2'd2, 1'b0, 2'd2, 16'h0708, 1'b0);
      // wrong destination, MF set, nonzero offset, total_len below header
      hdr(4'd5, 16'd28, 8'd6, 32'hC0A8_0002, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b1, 2'd2, -1);
      ign(16'h0102);
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h2000, 16'h0, 10, 1'b0, 1'b0, 1'b1, 2'd2, -1);
      ign(16'h0102);
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0001, 16'h0, 10, 1'b0, 1'b0, 1'b1, 2'd2, -1);
      ign(16'h0102);
      hdr(4'd5, 16'd18, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b1, 2'd2, -1);
      ign(16'h0102);
      // corrupted checksum: dropped only when checking is built in
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0001, 10, 1'b0, 1'b0, CSUM, 2'd2, -1);
      push(1'b1, 1'b0, 16'h0102, 2'd2, !CSUM, !CSUM, 2'd2, 16'h0102, 1'b0, 1'b0);
      push(1'b1, 1'b0, 16'h0304, 2'd2, !CSUM, 1'b0, 2'd2, 16'h0304, 1'b0, 1'b0);
      push(1'b1, 1'b0, 16'h0506, 2'd2, !CSUM, 1'b0, 2'd2, 16'h0506, 1'b0, 1'b0);
      push(1'b1, 1'b0, 16'h0708, 2'd2, !CSUM, 1'b0, 2'd2, 16'h0708, 1'b0, 1'b0);
      // early reject on word 0: bad version, then IHL<5
      push(1'b1, 1'b1, 16'h6500, 2'd2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
      ign(16'h001C); ign(16'h1111); ign(16'h2222);
      push(1'b1, 1'b1, 16'h4400, 2'd2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
      ign(16'h001C);
      // zero-length payload, and its short-last-word variant: silent
      hdr(4'd5, 16'd20, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      ign(16'h0000); ign(16'h0000);
      hdr(4'd5, 16'd20, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd1, -1);
      ign(16'h0000);
      // truncated header
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 3, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      push(1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
      ign(16'h0006); ign(16'h0000);
      // restart during header, then good packet
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 4, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b1, 1'b0, 1'b0, 2'd2, -1);
      pay4();
      // restart at second payload beat
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      pay(16'h0102, 2'd2, 1'b1, 2'd2, 16'h0102, 1'b0);
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b1, 1'b0, 2'd2, -1);
      pay4();
      // restart on what would be the final payload beat
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      pay(16'h0102, 2'd2, 1'b1, 2'd2, 16'h0102, 1'b0);
      pay(16'h0304, 2'd2, 1'b0, 2'd2, 16'h0304, 1'b0);
      pay(16'h0506, 2'd2, 1'b0, 2'd2, 16'h0506, 1'b0);
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b1, 1'b0, 2'd2, -1);
      pay4();
      // MAC-truncated payload: forwarded with cancel, remainder ignored
      hdr(4'd5, 16'd28, 8'd6, LIP, 16'h0, 16'h0, 10, 1'b0, 1'b0, 1'b0, 2'd2, -1);
      pay(16'h0102, 2'd2, 1'b1, 2'd2, 16'h0102, 1'b0);
      pay(16'h0344, 2'd1, 1'b0, 2'd1, 16'h0300, 1'b1);
      ign(16'h0506);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst start_o", {31'd0, start_o}, 32'd0);
      chk("rst drop_o", {31'd0, drop_o}, 32'd0);
      chk("rst cancel_o", {31'd0, cancel_o}, 32'd0);
      chk("rst len_o", {30'd0, len_o}, 32'd0);
      chk("rst data_o", {16'd0, data_o}, 32'd0);
      chk("rst src_ip_o", src_ip_o, 32'd0);
      reset = 1'b0;

      foreach (vq[i]) begin
         valid_i = vq[i].v; start_i = vq[i].s; data_i = vq[i].d; len_i = vq[i].l;
         @(posedge clk); #1;
         checks++;
         ok = (valid_o === vq[i].ev) && (start_o === vq[i].es) &&
              (drop_o === vq[i].edrop) && (cancel_o === vq[i].ecan) &&
              (!vq[i].ev || ((len_o === vq[i].el) && (data_o === vq[i].ed)));
         if (!ok) begin
            errors++;
            $display("FAIL vec %0d: got v=%b s=%b l=%0d d=%h drop=%b cancel=%b, expected v=%b s=%b l=%0d d=%h drop=%b cancel=%b",
                     i, valid_o, start_o, len_o, data_o, drop_o, cancel_o,
                     vq[i].ev, vq[i].es, vq[i].el, vq[i].ed, vq[i].edrop, vq[i].ecan);
         end
      end

      // source address capture, then reset in the middle of DATA
      mk_hdr(4'd5, 16'd28, 8'd6, LIP, 32'h0A00_0063, 16'h0, 16'h0);
      for (int i = 0; i < 10; i++) beat(i == 0, hw[i], 2'd2);
      chk("src_ip_o after accept", src_ip_o, 32'h0A00_0063);
      beat(1'b0, 16'h0102, 2'd2);
      chk("first beat valid_o", {31'd0, valid_o}, 32'd1);
      chk("first beat start_o", {31'd0, start_o}, 32'd1);
      chk("src_ip_o stable", src_ip_o, 32'h0A00_0063);
      reset = 1'b1;
      beat(1'b0, 16'h0304, 2'd2);
      chk("midrst valid_o", {31'd0, valid_o}, 32'd0);
      chk("midrst cancel_o", {31'd0, cancel_o}, 32'd0);
      chk("midrst data_o", {16'd0, data_o}, 32'd0);
      chk("midrst len_o", {30'd0, len_o}, 32'd0);
      chk("midrst src_ip_o", src_ip_o, 32'd0);
      reset = 1'b0;
      beat(1'b0, 16'h0506, 2'd2);
      chk("post rst idle valid_o", {31'd0, valid_o}, 32'd0);
      chk("post rst cancel_o", {31'd0, cancel_o}, 32'd0);
      valid_i = 1'b0;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
